// File: rtl/bubble_seq_pkg.sv
// ---------------------------------------------------------------------------
// bubble_seq_pkg
// Shared definitions for the bubble data sequencer:
//   - state_t          : sequencer FSM states (IDLE / FETCH / READY / DRIVE)
//   - DEF_POSITION_*   : default minor-loop geometry (2053 positions, 12 bits)
//   - SYNC_STAGES      : depth of the clock-domain synchroniser on each
//                        timing input
// ---------------------------------------------------------------------------
package bubble_seq_pkg;

   localparam int DEF_POSITION_COUNT = 2053;
   localparam int DEF_POSITION_WIDTH = 12;
   localparam int SYNC_STAGES        = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_READY = 2'd2,
      ST_DRIVE = 2'd3
   } state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// ---------------------------------------------------------------------------
// sync_edge_detect
// Brings one timing input from the derived 12MHz domain into master_clock
// through a SYNC_STAGES-flop synchroniser and produces a one-cycle pulse on
// its rising edge.
// Ports:
//   i_clk    in   master clock
//   i_rst_n  in   asynchronous active-low reset (all flops clear to 0)
//   i_async  in   asynchronous level to be synchronised
//   o_level  out  synchronised level
//   o_rise   out  one-cycle pulse when o_level goes 0 -> 1
// ---------------------------------------------------------------------------
module sync_edge_detect
   import bubble_seq_pkg::*;
(
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_async,
   output logic o_level,
   output logic o_rise
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync <= '0;
         r_prev <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
         r_prev <= r_sync[SYNC_STAGES-1];
      end
   end

   assign o_level = r_sync[SYNC_STAGES-1];
   assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/bubble_data_sequencer.sv
// ---------------------------------------------------------------------------
// bubble_data_sequencer
// Emulates the MB3908 sense-amp output behind an MB14506 timing-generator
// emulation. Tracks the absolute bubble position, fetches one bit per
// position_latch from a page buffer (req/ack), and drives it active-low on
// bubble_out_n during the data_out_strobe window.
//
// Ports:
//   master_clock      in   single clock (48MHz)
//   reset_n           in   asynchronous active-low reset
//   position_change   in   field-rotation pulse (12MHz domain)
//   position_latch    in   replicate window (12MHz domain)
//   data_out_strobe   in   detector strobe window (12MHz domain)
//   coil_run          in   high while the field rotates (12MHz domain)
//   page_select       in   bootloop/program page select (12MHz domain)
//   fetch_req         out  buffer read request, level
//   fetch_page        out  page qualifier of the fetch
//   fetch_addr        out  position being fetched
//   fetch_ack         in   one-cycle ack, fetch_data valid in the same cycle
//   fetch_data        in   bubble bit, 1 = bubble present
//   bubble_out_n      out  emulated detector output, active low
//   current_position  out  live position counter
//   underrun          out  sticky: strobe arrived before the bit was fetched
//   overrun           out  sticky: latch arrived while a transfer was busy
//
// Optional build macro BUBBLE_SEQ_STATS_EN adds:
//   fetch_count       out  [15:0] completed fetches, saturating
//   underrun_count    out  [15:0] underrun events, saturating
// ---------------------------------------------------------------------------
module bubble_data_sequencer
   import bubble_seq_pkg::*;
#(
   parameter int POSITION_COUNT   = DEF_POSITION_COUNT,
   parameter int POSITION_WIDTH   = DEF_POSITION_WIDTH,
   parameter int INITIAL_POSITION = 0
) (
   input  logic                      master_clock,
   input  logic                      reset_n,
   input  logic                      position_change,
   input  logic                      position_latch,
   input  logic                      data_out_strobe,
   input  logic                      coil_run,
   input  logic                      page_select,
   output logic                      fetch_req,
   output logic                      fetch_page,
   output logic [POSITION_WIDTH-1:0] fetch_addr,
   input  logic                      fetch_ack,
   input  logic                      fetch_data,
`ifdef BUBBLE_SEQ_STATS_EN
   output logic [15:0]               fetch_count,
   output logic [15:0]               underrun_count,
`endif
   output logic                      bubble_out_n,
   output logic [POSITION_WIDTH-1:0] current_position,
   output logic                      underrun,
   output logic                      overrun
);

   // Synchronised timing inputs
   logic w_pc_lv, w_pc_rise;
   logic w_lt_lv, w_lt_rise;
   logic w_st_lv, w_st_rise;
   logic w_cr_lv, w_cr_rise;
   logic w_ps_lv, w_ps_rise;

   sync_edge_detect u_sync_pc (
      .i_clk   (master_clock),
      .i_rst_n (reset_n),
      .i_async (position_change),
      .o_level (w_pc_lv),
      .o_rise  (w_pc_rise)
   );

   sync_edge_detect u_sync_lt (
      .i_clk   (master_clock),
      .i_rst_n (reset_n),
      .i_async (position_latch),
      .o_level (w_lt_lv),
      .o_rise  (w_lt_rise)
   );

   sync_edge_detect u_sync_st (
      .i_clk   (master_clock),
      .i_rst_n (reset_n),
      .i_async (data_out_strobe),
      .o_level (w_st_lv),
      .o_rise  (w_st_rise)
   );

   sync_edge_detect u_sync_cr (
      .i_clk   (master_clock),
      .i_rst_n (reset_n),
      .i_async (coil_run),
      .o_level (w_cr_lv),
      .o_rise  (w_cr_rise)
   );

   sync_edge_detect u_sync_ps (
      .i_clk   (master_clock),
      .i_rst_n (reset_n),
      .i_async (page_select),
      .o_level (w_ps_lv),
      .o_rise  (w_ps_rise)
   );

   // Each synchroniser offers both level and edge; these are the ones the
   // sequencer has no use for.
   logic w_unused;
   assign w_unused = &{w_pc_lv, w_lt_lv, w_cr_rise, w_ps_rise};

   // Registers
   state_t                    r_state;
   logic                      r_req;
   logic                      r_page;
   logic [POSITION_WIDTH-1:0] r_addr;
   logic [POSITION_WIDTH-1:0] r_position;
   logic                      r_bubble_n;
   logic                      r_underrun;
   logic                      r_overrun;
   logic                      r_late;      // strobe already missed for this fetch
   logic                      r_cr_lv_d;   // previous synced coil_run, for fall detect
   logic                      r_bit;

   logic w_coil_fall;
   logic w_fetch_done;
   logic w_underrun_evt;

   assign w_coil_fall    = r_cr_lv_d & ~w_cr_lv;
   // A coil stop in the same cycle as the ack aborts the transfer instead.
   assign w_fetch_done   = (r_state == ST_FETCH) & fetch_ack & ~w_coil_fall;
   assign w_underrun_evt = (r_state == ST_FETCH) & w_st_rise & ~w_coil_fall;

   // Position counter: bubbles move only while the field rotates.
   always_ff @(posedge master_clock or negedge reset_n) begin
      if (!reset_n) begin
         r_position <= POSITION_WIDTH'(INITIAL_POSITION);
      end else if (w_pc_rise && w_cr_lv) begin
         if (r_position == POSITION_WIDTH'(POSITION_COUNT - 1))
            r_position <= '0;
         else
            r_position <= r_position + POSITION_WIDTH'(1);
      end
   end

   // Sequencer FSM. The latch captures r_position before this cycle's
   // increment, so a coincident position_change never skews the address.
   always_ff @(posedge master_clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= ST_IDLE;
         r_req      <= 1'b0;
         r_page     <= 1'b0;
         r_addr     <= '0;
         r_bubble_n <= 1'b1;
         r_underrun <= 1'b0;
         r_overrun  <= 1'b0;
         r_late     <= 1'b0;
         r_cr_lv_d  <= 1'b0;
      end else begin
         r_cr_lv_d <= w_cr_lv;

         if (w_lt_rise && (r_state != ST_IDLE))
            r_overrun <= 1'b1;
         if (w_underrun_evt)
            r_underrun <= 1'b1;

         case (r_state)
            ST_IDLE: begin
               if (w_lt_rise) begin
                  r_addr  <= r_position;
                  r_page  <= w_ps_lv;
                  r_req   <= 1'b1;
                  r_late  <= 1'b0;
                  r_state <= ST_FETCH;
               end
            end
            ST_FETCH: begin
               if (w_coil_fall) begin
                  r_req   <= 1'b0;
                  r_late  <= 1'b0;
                  r_state <= ST_IDLE;
               end else if (fetch_ack) begin
                  // A late ack is consumed but its window has passed.
                  r_req   <= 1'b0;
                  r_late  <= 1'b0;
                  r_state <= (r_late || w_st_rise) ? ST_IDLE : ST_READY;
               end else if (w_st_rise) begin
                  r_late <= 1'b1;
               end
            end
            ST_READY: begin
               if (w_coil_fall) begin
                  r_state <= ST_IDLE;
               end else if (w_st_rise) begin
                  r_bubble_n <= ~r_bit;
                  r_state    <= ST_DRIVE;
               end
            end
            ST_DRIVE: begin
               // Coil stop is deliberately ignored here: the window completes.
               if (!w_st_lv) begin
                  r_bubble_n <= 1'b1;
                  r_state    <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge master_clock) begin
      if (w_fetch_done)
         r_bit <= fetch_data;
   end

`ifdef BUBBLE_SEQ_STATS_EN
   logic [15:0] r_fetch_count;
   logic [15:0] r_underrun_count;

   always_ff @(posedge master_clock or negedge reset_n) begin
      if (!reset_n) begin
         r_fetch_count    <= '0;
         r_underrun_count <= '0;
      end else begin
         if (w_fetch_done && (r_fetch_count != 16'hFFFF))
            r_fetch_count <= r_fetch_count + 16'd1;
         if (w_underrun_evt && (r_underrun_count != 16'hFFFF))
            r_underrun_count <= r_underrun_count + 16'd1;
      end
   end

   assign fetch_count    = r_fetch_count;
   assign underrun_count = r_underrun_count;
`endif

   assign fetch_req        = r_req;
   assign fetch_page       = r_page;
   assign fetch_addr       = r_addr;
   assign bubble_out_n     = r_bubble_n;
   assign current_position = r_position;
   assign underrun         = r_underrun;
   assign overrun          = r_overrun;

endmodule
